dec8b10b_rx_sync: RTL
=====================

# dec8b10b_rx_sync

Receive-side sequencer for the combinational 8b/10b decoder. It holds the running-disparity register that feeds the decoder's disparity input and qualifies each decoded word as valid or invalid. A comma-based synchronisation state machine (simplified IEEE 802.3 clause 36) decides when decoded bytes are forwarded downstream. It also maintains an optional saturating error counter.

## Interface
Parameters:
- COMMA_CNT, 3: consecutive-acquisition comma count (K28.5) needed to declare sync; legal 1..15.
- MAX_BAD, 4: net invalid words in SYNC that cause loss of sync; legal 1..15.
- GOOD_RUN, 4: consecutive valid words that reduce the bad level by one; legal 1..15.
- ERR_W, 16: error counter width.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  a new 10-bit symbol is present at the decoder this cycle.
- dec_data  in  9  decoder dataout {K, HGFEDCBA}.
- dec_dispout  in  1  decoder running disparity after this symbol.
- dec_code_err  in  1  decoder code error.
- dec_disp_err  in  1  decoder disparity error.
- dec_dispin  out  1  running-disparity register to decoder (0 = RD−).
- out_valid  out  1  forwarded word strobe.
- out_data  out  8  forwarded byte.
- out_k  out  1  forwarded control flag.
- out_err  out  1  forwarded word was invalid.
- sync_ok  out  1  state == SYNC.
- err_clr  in  1  synchronous clear of err_cnt.
- err_cnt  out  ERR_W  saturating invalid-word count.

## Operation
- Word is "accepted" on a cycle with in_valid=1. No other input is sampled while in_valid=0, except err_clr.
- comma = dec_data == 9'h1BC (K28.5). invalid = dec_code_err | dec_disp_err.
- Running disparity: on every accepted word, rd <= dec_dispout, in all states. dec_dispin = rd.
- State LOS:
  - comma with !dec_code_err goes to CDET with ccnt=1. dec_disp_err is ignored here because rd may be wrong.
  - If COMMA_CNT==1, go directly to SYNC.
  - All other words leave the state in LOS.
- State CDET:
  - Invalid word goes to LOS and clears ccnt.
  - comma increments ccnt; when ccnt reaches COMMA_CNT, go to SYNC and clear bad and gcnt.
  - A valid non-comma word holds the state.
- State SYNC:
  - Invalid word: bad+1 and gcnt=0. If bad+1 == MAX_BAD, go to LOS.
  - Valid word with bad>0: gcnt+1. When gcnt+1 == GOOD_RUN, bad−1 and gcnt=0.
  - Valid word with bad==0: gcnt is held at 0.
- Forwarding:
  - A word is forwarded iff the state register is SYNC on its acceptance cycle.
  - The word that triggers SYNC→LOS is still forwarded, with out_err=1.
  - The comma completing acquisition is not forwarded.
- Error counter: increments on each forwarded invalid word and saturates at all-ones. err_clr has priority and gives 0 even if an invalid word is accepted that cycle.

## Timing
- Reset values: state LOS, rd 0, ccnt/bad/gcnt 0, out_valid 0, out_data 0, out_k 0, out_err 0, sync_ok 0, err_cnt 0.
- Latency: accepted word at edge N gives out_* valid after edge N+1 (one register stage). out_valid is a single-cycle pulse per forwarded word.
- sync_ok rises the cycle after the completing comma and falls the cycle after the word that causes loss.
- dec_dispin changes the cycle after each accepted word. The path rd→decoder→dec_dispout→rd is one combinational cycle.
- Back-to-back in_valid every cycle is supported. Gaps do not alter any counter.
- rst_n low mid-stream returns to LOS on the next edge and drops any in-flight out_valid.

## Configuration
- DEC_SYNC_ERRCNT_EN defined: error counter is implemented as above.
- Not defined: err_cnt is constant 0, err_clr is ignored, and no counter flops exist. All other behaviour is identical.

## Test plan
- Acquisition: reset, then K28.5(RD−), D5.6, K28.5, D16.2, K28.5, D21.5, all valid.
  - sync_ok=1 one cycle after the 3rd comma.
  - D21.5 is forwarded: out_data=8'hB5, out_k=0.
  - Nothing before D21.5 is forwarded.
- Loss: in SYNC, four code-error words separated by two valid words each, with GOOD_RUN=4.
  - sync_ok=0 after the 4th error.
  - err_cnt=4 (macro on), and out_err=1 on all four.
- Recovery: in SYNC, one invalid word then 4 valid words.
  - bad returns to 0 and sync is kept.
  - A further 3 invalid words alone do not drop sync; the 4th does.
- Disparity tracking: send K28.5 encoded with RD+ while rd=0 in LOS.
  - Comma is accepted and dec_dispin follows dec_dispout.
  - The same symbol in CDET returns to LOS.
- Counter edge: with ERR_W=2, send 5 invalid words in SYNC with MAX_BAD=15 → err_cnt saturates at 3.
  - Then err_clr together with an invalid word → err_cnt=0 next cycle.
- Reset mid-operation: assert rst_n=0 for one cycle while in SYNC with out_valid pending.
  - Next cycle: all outputs at reset values and state LOS.

Source files
------------

// File: rtl/dec8b10b_rx_sync.sv
// Receive sequencer behind the combinational 8b/10b decoder: running-disparity register,
// K28.5 sync FSM and word forwarding. Define DEC_SYNC_ERRCNT_EN to build the error counter.
module dec8b10b_rx_sync #(
  parameter int COMMA_CNT = 3,
  parameter int MAX_BAD   = 4,
  parameter int GOOD_RUN  = 4,
  parameter int ERR_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [8:0]       dec_data,
  input  logic             dec_dispout,
  input  logic             dec_code_err,
  input  logic             dec_disp_err,
  output logic             dec_dispin,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_k,
  output logic             out_err,
  output logic             sync_ok,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_cnt
);
  localparam logic [8:0] K28_5   = 9'h1BC;
  localparam logic [3:0] COMMA_N = 4'(COMMA_CNT);
  localparam logic [3:0] MAX_N   = 4'(MAX_BAD);
  localparam logic [3:0] GOOD_N  = 4'(GOOD_RUN);

  typedef enum logic [1:0] {LOS, CDET, SYNC} state_t;

  state_t     state;
  logic [3:0] ccnt, bad, gcnt;
  logic       rd;
  logic       comma, invalid;

  assign comma      = (dec_data == K28_5);
  assign invalid    = dec_code_err | dec_disp_err;
  assign dec_dispin = rd;
  assign sync_ok    = (state == SYNC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LOS;
      rd        <= 1'b0;
      ccnt      <= '0;
      bad       <= '0;
      gcnt      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_k     <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        rd <= dec_dispout;
        case (state)
          LOS: begin
            // disparity error ignored: rd is untrusted until aligned
            if (comma && !dec_code_err) begin
              if (COMMA_N == 4'd1) begin
                state <= SYNC;
                ccnt  <= '0;
                bad   <= '0;
                gcnt  <= '0;
              end else begin
                state <= CDET;
                ccnt  <= 4'd1;
              end
            end
          end
          CDET: begin
            if (invalid) begin
              state <= LOS;
              ccnt  <= '0;
            end else if (comma) begin
              if (ccnt + 4'd1 == COMMA_N) begin
                state <= SYNC;
                ccnt  <= '0;
                bad   <= '0;
                gcnt  <= '0;
              end else begin
                ccnt <= ccnt + 4'd1;
              end
            end
          end
          SYNC: begin
            out_valid <= 1'b1;
            out_data  <= dec_data[7:0];
            out_k     <= dec_data[8];
            out_err   <= invalid;
            if (invalid) begin
              gcnt <= '0;
              if (bad + 4'd1 == MAX_N) begin
                state <= LOS;
                bad   <= '0;
              end else begin
                bad <= bad + 4'd1;
              end
            end else if (bad != 4'd0) begin
              // a full run of good words earns back one bad credit
              if (gcnt + 4'd1 == GOOD_N) begin
                bad  <= bad - 4'd1;
                gcnt <= '0;
              end else begin
                gcnt <= gcnt + 4'd1;
              end
            end else begin
              gcnt <= '0;
            end
          end
          default: state <= LOS;
        endcase
      end
    end
  end

`ifdef DEC_SYNC_ERRCNT_EN
  logic [ERR_W-1:0] err_q;

  always_ff @(posedge clk) begin
    if (!rst_n || err_clr)
      err_q <= '0;
    else if (in_valid && state == SYNC && invalid && err_q != '1)
      err_q <= err_q + ERR_W'(1);
  end

  assign err_cnt = err_q;
`else
  logic unused_clr;
  assign unused_clr = err_clr;
  assign err_cnt    = '0;
`endif

endmodule
